// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types and constants for the washing-machine cycle sequencer
//
// Contents:
//   wm_state_e      - 3-bit cycle state encoding (also driven on state_o)
//   DEF_*_T         - default phase durations in timer counts
//   DUR_MIN/DUR_MAX - legal phase duration range
//   is_timed()      - true for the states that run the phase timer
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } wm_state_e;

  localparam int DEF_FILL_T  = 3;
  localparam int DEF_WASH_T  = 5;
  localparam int DEF_RINSE_T = 4;
  localparam int DEF_SPIN_T  = 6;

  localparam int DUR_MIN = 1;
  localparam int DUR_MAX = 15;

  function automatic logic is_timed(wm_state_e s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wm_cycle_ctrl_out_decode.sv
// rtl/wm_cycle_ctrl_out_decode.sv - state/paused to actuator decode for the cycle sequencer
//
// Module wm_out_decode (purely combinational; the top level registers the results).
// Ports:
//   state_i      in  3  state being entered (wm_state_e encoding)
//   paused_i     in  1  phase is paused because the lid is open
//   valve_open_o out 1  FILL
//   motor_on_o   out 1  WASH, RINSE, SPIN
//   motor_fast_o out 1  SPIN
//   drain_o      out 1  RINSE, SPIN
//   door_lock_o  out 1  any state but IDLE, regardless of pause
//   done_o       out 1  DONE
module wm_out_decode
  import wm_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic       paused_i,
  output logic       valve_open_o,
  output logic       motor_on_o,
  output logic       motor_fast_o,
  output logic       drain_o,
  output logic       door_lock_o,
  output logic       done_o
);

  wm_state_e st;
  logic      act;

  assign st  = wm_state_e'(state_i);
  // Actuators must be safe while the lid is open; the door stays locked.
  assign act = ~paused_i;

  assign valve_open_o = act && (st == ST_FILL);
  assign motor_on_o   = act && ((st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN));
  assign motor_fast_o = act && (st == ST_SPIN);
  assign drain_o      = act && ((st == ST_RINSE) || (st == ST_SPIN));
  assign door_lock_o  = (st != ST_IDLE);
  assign done_o       = (st == ST_DONE);

endmodule

// File: rtl/wm_cycle_ctrl.sv
// rtl/wm_cycle_ctrl.sv - washing-machine cycle sequencer driving an external 4-bit phase timer
//
// Optional feature macro: WM_DOUBLE_WASH_EN (repeat WASH+RINSE once before SPIN).
// Parameters: FILL_T, WASH_T, RINSE_T, SPIN_T - phase durations in timer counts, 1..15.
// Ports:
//   clk_i          in  1  clock, rising edge
//   reset_i        in  1  asynchronous active-high reset
//   start_i        in  1  start request, only looked at in IDLE
//   lid_closed_i   in  1  low pauses a timed phase
//   cancel_i       in  1  abort to IDLE
//   timer_count_i  in  4  phase timer count
//   timer_en_o     out 1  phase timer enable
//   timer_rst_o    out 1  phase timer synchronous clear
//   valve_open_o, motor_on_o, motor_fast_o, drain_o, door_lock_o  out 1  actuators
//   done_o         out 1  one-cycle end-of-cycle pulse
//   state_o        out 3  current state (wm_state_e)
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int FILL_T  = DEF_FILL_T,
  parameter int WASH_T  = DEF_WASH_T,
  parameter int RINSE_T = DEF_RINSE_T,
  parameter int SPIN_T  = DEF_SPIN_T
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       lid_closed_i,
  input  logic       cancel_i,
  input  logic [3:0] timer_count_i,
  output logic       timer_en_o,
  output logic       timer_rst_o,
  output logic       valve_open_o,
  output logic       motor_on_o,
  output logic       motor_fast_o,
  output logic       drain_o,
  output logic       door_lock_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  if ((FILL_T  < DUR_MIN) || (FILL_T  > DUR_MAX) ||
      (WASH_T  < DUR_MIN) || (WASH_T  > DUR_MAX) ||
      (RINSE_T < DUR_MIN) || (RINSE_T > DUR_MAX) ||
      (SPIN_T  < DUR_MIN) || (SPIN_T  > DUR_MAX)) begin : g_bad_dur
    $error("wm_cycle_ctrl: phase durations must lie in 1..15");
  end

  function automatic logic [3:0] dur_of(wm_state_e s);
    logic [3:0] d;
    case (s)
      ST_FILL:  d = 4'(FILL_T);
      ST_WASH:  d = 4'(WASH_T);
      ST_RINSE: d = 4'(RINSE_T);
      ST_SPIN:  d = 4'(SPIN_T);
      default:  d = 4'd0;
    endcase
    return d;
  endfunction

  wm_state_e state_q, state_d, next_phase;
  logic      paused_q, paused_d;
  logic      timer_en_q, timer_en_d;
  logic      timer_rst_q, timer_rst_d;
  logic      phase_done;
  logic      rinse_repeat;

  logic valve_q, motor_q, fast_q, drain_q, lock_q, done_q;
  logic valve_d, motor_d, fast_d, drain_d, lock_d, done_d;

`ifdef WM_DOUBLE_WASH_EN
  // Set when the first RINSE hands back to WASH; the second RINSE then goes to SPIN.
  logic pass_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pass_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || cancel_i) begin
      pass_q <= 1'b0;
    end else if ((state_q == ST_RINSE) && (state_d == ST_WASH)) begin
      pass_q <= 1'b1;
    end
  end

  assign rinse_repeat = ~pass_q;
`else
  assign rinse_repeat = 1'b0;
`endif

  always_comb begin
    case (state_q)
      ST_FILL:  next_phase = ST_WASH;
      ST_WASH:  next_phase = ST_RINSE;
      ST_RINSE: next_phase = rinse_repeat ? ST_WASH : ST_SPIN;
      ST_SPIN:  next_phase = ST_DONE;
      default:  next_phase = ST_IDLE;
    endcase
  end

  // The count seen in the clear cycle is stale from the previous phase, so ignore it.
  assign phase_done = !timer_rst_q && (timer_count_i == dur_of(state_q));

  // Priority: cancel, then lid open, then resume, then phase completion.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    if (state_q == ST_IDLE) begin
      paused_d = 1'b0;
      if (start_i && lid_closed_i) begin
        state_d = ST_FILL;
      end
    end else if (cancel_i) begin
      state_d  = ST_IDLE;
      paused_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (!lid_closed_i) begin
      paused_d = 1'b1;
    end else if (paused_q) begin
      paused_d = 1'b0;
    end else if (phase_done) begin
      state_d = next_phase;
    end
  end

  // Entering a timed state or resuming from a pause restarts the timer from zero.
  assign timer_en_d  = is_timed(state_d) && !paused_d;
  assign timer_rst_d = timer_en_d && ((state_d != state_q) || paused_q);

  wm_out_decode u_out_decode (
    .state_i      (state_d),
    .paused_i     (paused_d),
    .valve_open_o (valve_d),
    .motor_on_o   (motor_d),
    .motor_fast_o (fast_d),
    .drain_o      (drain_d),
    .door_lock_o  (lock_d),
    .done_o       (done_d)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      paused_q    <= 1'b0;
      timer_en_q  <= 1'b0;
      timer_rst_q <= 1'b0;
      valve_q     <= 1'b0;
      motor_q     <= 1'b0;
      fast_q      <= 1'b0;
      drain_q     <= 1'b0;
      lock_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      timer_en_q  <= timer_en_d;
      timer_rst_q <= timer_rst_d;
      valve_q     <= valve_d;
      motor_q     <= motor_d;
      fast_q      <= fast_d;
      drain_q     <= drain_d;
      lock_q      <= lock_d;
      done_q      <= done_d;
    end
  end

  assign timer_en_o   = timer_en_q;
  assign timer_rst_o  = timer_rst_q;
  assign valve_open_o = valve_q;
  assign motor_on_o   = motor_q;
  assign motor_fast_o = fast_q;
  assign drain_o      = drain_q;
  assign door_lock_o  = lock_q;
  assign done_o       = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// tb/tb_wm_cycle_ctrl.sv - self-checking bench for wm_cycle_ctrl with an external phase timer model
module tb_wm_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       lid = 1'b1;
  logic       cancel = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       timer_en, timer_rst, valve, motor, fast, drain, door, done;
  logic [2:0] state;
  logic [10:0] obs;

  int vectors = 0;
  int miscompares = 0;

`ifdef WM_DOUBLE_WASH_EN
  localparam int NPH = 6;
  localparam int NOMINAL_DONE = 40;
`else
  localparam int NPH = 4;
  localparam int NOMINAL_DONE = 27;
`endif

  wm_cycle_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .lid_closed_i  (lid),
    .cancel_i      (cancel),
    .timer_count_i (cnt),
    .timer_en_o    (timer_en),
    .timer_rst_o   (timer_rst),
    .valve_open_o  (valve),
    .motor_on_o    (motor),
    .motor_fast_o  (fast),
    .drain_o       (drain),
    .door_lock_o   (door),
    .done_o        (done),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  // External 4-bit phase timer: synchronous clear, clears itself when disabled.
  always @(posedge clk) cnt <= (timer_rst || !timer_en) ? 4'd0 : cnt + 4'd1;

  assign obs = {state, timer_en, timer_rst, valve, motor, fast, drain, door, done};

  function automatic int phase_at(int p);
`ifdef WM_DOUBLE_WASH_EN
    case (p)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 2;
      4: return 3;
      default: return 4;
    endcase
`else
    case (p)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 4;
    endcase
`endif
  endfunction

  function automatic int dur(int st);
    case (st)
      1: return 3;
      2: return 5;
      3: return 4;
      4: return 6;
      default: return 0;
    endcase
  endfunction

  // Expected outputs from the spec's rules: state, paused, first cycle of a (re)started phase.
  function automatic logic [10:0] exp_vec(int st, bit paused, bit first);
    bit timed, act;
    timed = (st >= 1) && (st <= 4);
    act   = timed && !paused;
    return {3'(st), act, act && first, act && (st == 1), act && (st >= 2) && (st <= 4),
            act && (st == 4), act && (st == 3 || st == 4), (st != 0), (st == 5)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; lid = 1'b1; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, 11'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (obs !== exp_vec(0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b want %b", obs, exp_vec(0, 0, 0));
    end
  endtask

  task automatic test_start_no_lid();
    start = 1'b1; lid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs !== exp_vec(0, 0, 0)) begin
        miscompares++;
        $display("FAIL start_no_lid cycle %0d: got %b want %b", i, obs, exp_vec(0, 0, 0));
      end
    end
    start = 1'b0; lid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int total, rem, st, len, done_at, valve_cycles;
    bit first, found;
    total = 0;
    for (int p = 0; p < NPH; p++) total += dur(phase_at(p)) + 2;
    done_at = -1;
    valve_cycles = 0;
    start = 1'b1; lid = 1'b1;
    for (int c = 1; c <= total + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      st = 0; first = 1'b0;
      if (c == total + 1) st = 5;
      else if (c <= total) begin
        rem = c - 1;
        found = 1'b0;
        for (int p = 0; p < NPH; p++) begin
          len = dur(phase_at(p)) + 2;
          if (!found && rem < len) begin
            st = phase_at(p);
            first = (rem == 0);
            found = 1'b1;
          end else if (!found) begin
            rem -= len;
          end
        end
      end
      vectors++;
      if (obs !== exp_vec(st, 0, first)) begin
        miscompares++;
        $display("FAIL nominal cycle %0d: got %b want %b", c, obs, exp_vec(st, 0, first));
      end
      if (done) done_at = c;
      if (valve) valve_cycles++;
    end
    vectors++;
    if (done_at != NOMINAL_DONE) begin
      miscompares++;
      $display("FAIL nominal_done_cycle: got %0d want %0d", done_at, NOMINAL_DONE);
    end
    vectors++;
    if (valve_cycles != 5) begin
      miscompares++;
      $display("FAIL nominal_valve_cycles: got %0d want 5", valve_cycles);
    end
  endtask

  task automatic test_lid_pause();
    logic [4:0] expq[$];
    int pph, poff, plen, len, idle_pre, st;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        pph = 1; poff = 4; plen = 3;
      end else begin
        pph  = $urandom_range(0, NPH - 1);
        poff = $urandom_range(1, dur(phase_at(pph)) + 2);
        plen = $urandom_range(1, 4);
      end
      expq.delete();
      for (int p = 0; p < NPH; p++) begin
        st  = phase_at(p);
        len = dur(st) + 2;
        if (p == pph) begin
          for (int j = 0; j < poff; j++) expq.push_back({3'(st), 1'b0, (j == 0)});
          for (int j = 0; j < plen; j++) expq.push_back({3'(st), 1'b1, 1'b0});
        end
        for (int j = 0; j < len; j++) expq.push_back({3'(st), 1'b0, (j == 0)});
      end
      expq.push_back({3'd5, 1'b0, 1'b0});
      expq.push_back({3'd0, 1'b0, 1'b0});

      idle_pre = $urandom_range(0, 3);
      for (int i = 0; i < idle_pre; i++) begin
        start = 1'b0;
        lid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        vectors++;
        if (obs !== exp_vec(0, 0, 0)) begin
          miscompares++;
          $display("FAIL pause_idle it %0d: got %b want %b", it, obs, exp_vec(0, 0, 0));
        end
      end
      start = 1'b1; lid = 1'b1;
      for (int k = 0; k < expq.size(); k++) begin
        @(posedge clk); #1;
        vectors++;
        if (obs !== exp_vec(int'(expq[k][4:2]), expq[k][1], expq[k][0])) begin
          miscompares++;
          $display("FAIL pause it %0d cycle %0d: got %b want %b", it, k, obs,
                   exp_vec(int'(expq[k][4:2]), expq[k][1], expq[k][0]));
        end
        if (k + 1 < expq.size()) begin
          lid   = !expq[k + 1][1];
          start = 1'($urandom_range(0, 1));
        end else begin
          lid   = 1'b1;
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic test_cancel();
    int n;
    start = 1'b1; lid = 1'b1; cancel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (state !== 3'd4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (state !== 3'd4) begin
      miscompares++;
      $display("FAIL cancel_reach_spin: got state %0d want 4", state);
    end
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1; lid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (obs !== exp_vec(0, 0, 0)) begin
      miscompares++;
      $display("FAIL cancel_to_idle: got %b want %b", obs, exp_vec(0, 0, 0));
    end
    cancel = 1'b0; lid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs !== exp_vec(0, 0, 0)) begin
        miscompares++;
        $display("FAIL cancel_after cycle %0d: got %b want %b", i, obs, exp_vec(0, 0, 0));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    start = 1'b1; lid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (state !== 3'd3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (state !== 3'd3) begin
      miscompares++;
      $display("FAIL reset_reach_rinse: got state %0d want 3", state);
    end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, 11'd0);
    end
    @(posedge clk); #1;
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset_held: got %b want %b", obs, 11'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs !== exp_vec(0, 0, 0)) begin
        miscompares++;
        $display("FAIL async_reset_after cycle %0d: got %b want %b", i, obs, exp_vec(0, 0, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_no_lid();
    test_nominal();
    test_lid_pause();
    test_cancel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
